pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Drives per-stage enable/flush: run, single-step, halt freeze, restart-clear,
//  load-use stall and taken-branch flush. Sits beside the debug unit, between
//  the hazard detector and the stage registers.
// PARAMETERS
//  CLEAR_CYCLES  2   cycles all stage flushes are held in CLEAR (>=1)
//  CNT_SIZE      32  width of perf counters (PIPE_PERF_CNT_EN only)
// PORTS
//  i_clk           in   1         system clock, rising edge
//  i_reset         in   1         asynchronous, active-low reset
//  i_start         in   1         debug run request; rising edge acts
//  i_step          in   1         debug single-step request; rising edge acts
//  i_restart       in   1         leave HALTED via CLEAR; rising edge acts
//  i_load_use      in   1         hazard unit: load-use stall needed (level)
//  i_branch_taken  in   1         ID resolved taken branch/jump (level)
//  i_halt_wb       in   1         halt flag at MEM/WB register output (level)
//  o_en_pc         out  1         PC enable
//  o_en_if_id      out  1         IF/ID enable
//  o_en_id_ex      out  1         ID/EX enable
//  o_en_ex_mem     out  1         EX/MEM enable
//  o_en_mem_wb     out  1         MEM/WB enable
//  o_flush_if_id   out  1         IF/ID flush
//  o_flush_id_ex   out  1         ID/EX flush (bubble)
//  o_flush_ex_mem  out  1         EX/MEM flush
//  o_flush_mem_wb  out  1         MEM/WB flush
//  o_halted        out  1         registered; 1 while state==HALTED
//  o_state         out  3         IDLE=0 RUN=1 STEP=2 HALTED=3 CLEAR=4
// BEHAVIOUR
//  - Reset (async, i_reset=0): state=IDLE, edge regs=0, clear ctr=0, o_halted=0.
//    All enables/flushes are 0 (IDLE decode).
//  - Edge detect: i_start/i_step/i_restart are registered. Event = in & ~prev.
//  - Enables/flushes are combinational from state + current hazard inputs.
//    They take effect on the same clock edge.
//  - "RUN-decode" (used in RUN and STEP):
//    - Default: all five enables 1, all flushes 0.
//    - i_load_use: en_pc=0, en_if_id=0, flush_id_ex=1; branch flush is
//      suppressed that cycle (load_use has priority over i_branch_taken).
//    - i_branch_taken & ~i_load_use: flush_if_id=1, en_pc stays 1.
//    - i_halt_wb: all enables 0, all flushes 0 (overrides load_use/branch).
//  - IDLE: all 0.
//    - start event -> RUN; else step event -> STEP (start wins if both).
//  - RUN: RUN-decode.
//    - i_halt_wb -> HALTED.
//  - STEP: RUN-decode for exactly one cycle.
//    - Next state: HALTED if i_halt_wb, else IDLE.
//  - HALTED: all enables 0, o_halted=1 from the cycle after entry.
//    - restart event -> CLEAR, ctr=0. start/step events are ignored.
//  - CLEAR: all four flushes=1, en_pc=0, other enables 0.
//    - ctr increments each cycle; at ctr==CLEAR_CYCLES-1 -> IDLE.
//  - A reset asserted in any state returns to IDLE immediately.
//    No outstanding step or clear survives reset.
//  - Flush beats enable at the stage registers (their own rule).
//    Stalled stages therefore hold, and flushed stages clear.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined:
//    - adds o_cycle_cnt[CNT_SIZE] and o_stall_cnt[CNT_SIZE] outputs, reset 0.
//    - cycle_cnt +1 every cycle where state is RUN or STEP.
//    - stall_cnt +1 every RUN/STEP cycle with i_load_use & ~i_halt_wb.
//    - both wrap modulo 2^CNT_SIZE and are cleared on entry to CLEAR.
//  PIPE_PERF_CNT_EN undefined: ports and counters absent, behaviour otherwise identical.
// TESTING
//  1. Reset low 3 cycles, release -> all en/flush 0, o_state=0, o_halted=0.
//  2. Pulse i_start; next cycle i_load_use=1 for 1 cycle ->
//     o_state=1; en_pc=en_if_id=0, flush_id_ex=1 that cycle; all en=1 after.
//  3. RUN with i_load_use=1 and i_branch_taken=1 together ->
//     flush_if_id=0, flush_id_ex=1.
//     Branch alone next cycle -> flush_if_id=1, en_pc=1.
//  4. Hold i_step high 5 cycles from IDLE ->
//     exactly 1 cycle in STEP with all en=1, then IDLE.
//     A second step needs the input low then high again.
//  5. RUN, assert i_halt_wb ->
//     all en 0 that cycle, o_state=3 and o_halted=1 next cycle.
//     i_start pulse has no effect.
//     i_restart pulse -> 2 cycles of all flushes=1, then IDLE.
//  6. PIPE_PERF_CNT_EN: 10 RUN cycles incl. 3 load_use ->
//     cycle_cnt=10, stall_cnt=3; both read 0 after CLEAR.
//     Reset mid-CLEAR -> IDLE, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Debug, hazard and stage-register control bundle for pipeline_ctrl.
// PIPE_PERF_CNT_EN adds the cycle and stall counter outputs.
interface pipeline_ctrl_if
`ifdef PIPE_PERF_CNT_EN
    #(parameter int CNT_SIZE = 32)
`endif
    ;
    logic       i_start;
    logic       i_step;
    logic       i_restart;
    logic       i_load_use;
    logic       i_branch_taken;
    logic       i_halt_wb;
    logic       o_en_pc;
    logic       o_en_if_id;
    logic       o_en_id_ex;
    logic       o_en_ex_mem;
    logic       o_en_mem_wb;
    logic       o_flush_if_id;
    logic       o_flush_id_ex;
    logic       o_flush_ex_mem;
    logic       o_flush_mem_wb;
    logic       o_halted;
    logic [2:0] o_state;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_SIZE-1:0] o_cycle_cnt;
    logic [CNT_SIZE-1:0] o_stall_cnt;
`endif

    modport master (
        output i_start, i_step, i_restart, i_load_use, i_branch_taken, i_halt_wb,
`ifdef PIPE_PERF_CNT_EN
        input  o_cycle_cnt, o_stall_cnt,
`endif
        input  o_en_pc, o_en_if_id, o_en_id_ex, o_en_ex_mem, o_en_mem_wb,
        input  o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
        input  o_halted, o_state
    );

    modport slave (
        input  i_start, i_step, i_restart, i_load_use, i_branch_taken, i_halt_wb,
`ifdef PIPE_PERF_CNT_EN
        output o_cycle_cnt, o_stall_cnt,
`endif
        output o_en_pc, o_en_if_id, o_en_id_ex, o_en_ex_mem, o_en_mem_wb,
        output o_flush_if_id, o_flush_id_ex, o_flush_ex_mem, o_flush_mem_wb,
        output o_halted, o_state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Enable/flush sequencer for the five pipeline stage registers (run, step, halt, clear).
// Define PIPE_PERF_CNT_EN to add the RUN/STEP cycle and load-use stall counters.
module pipeline_ctrl #(
    parameter int CLEAR_CYCLES = 2
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_SIZE     = 32
`endif
) (
    input logic            i_clk,
    input logic            i_reset,
    pipeline_ctrl_if.slave bus
);
    localparam int CTR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        HALTED = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CTR_W-1:0] ctr_reg, ctr_next;
    logic             start_prev_reg, step_prev_reg, restart_prev_reg;
    logic             halted_reg;
    logic             start_evt, step_evt, restart_evt;
    logic [4:0]       en_vec;     // pc, if_id, id_ex, ex_mem, mem_wb
    logic [3:0]       flush_vec;  // if_id, id_ex, ex_mem, mem_wb

    assign start_evt   = bus.i_start   & ~start_prev_reg;
    assign step_evt    = bus.i_step    & ~step_prev_reg;
    assign restart_evt = bus.i_restart & ~restart_prev_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg        <= IDLE;
            ctr_reg          <= '0;
            start_prev_reg   <= 1'b0;
            step_prev_reg    <= 1'b0;
            restart_prev_reg <= 1'b0;
            halted_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ctr_reg          <= ctr_next;
            start_prev_reg   <= bus.i_start;
            step_prev_reg    <= bus.i_step;
            restart_prev_reg <= bus.i_restart;
            halted_reg       <= (state_next == HALTED);
        end
    end

    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        en_vec     = 5'b00000;
        flush_vec  = 4'b0000;
        case (state_reg)
            IDLE: begin
                if (start_evt)     state_next = RUN;
                else if (step_evt) state_next = STEP;
            end
            RUN, STEP: begin
                // Halt freezes everything; load-use stall masks a branch flush.
                if (bus.i_halt_wb) begin
                    en_vec = 5'b00000;
                end else if (bus.i_load_use) begin
                    en_vec       = 5'b00111;
                    flush_vec[2] = 1'b1;
                end else begin
                    en_vec       = 5'b11111;
                    flush_vec[3] = bus.i_branch_taken;
                end
                if (bus.i_halt_wb)         state_next = HALTED;
                else if (state_reg == STEP) state_next = IDLE;
            end
            HALTED: begin
                if (restart_evt) begin
                    state_next = CLEAR;
                    ctr_next   = '0;
                end
            end
            CLEAR: begin
                flush_vec = 4'b1111;
                if (ctr_reg == CTR_LAST) state_next = IDLE;
                else                     ctr_next   = ctr_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.o_en_pc        = en_vec[4];
    assign bus.o_en_if_id     = en_vec[3];
    assign bus.o_en_id_ex     = en_vec[2];
    assign bus.o_en_ex_mem    = en_vec[1];
    assign bus.o_en_mem_wb    = en_vec[0];
    assign bus.o_flush_if_id  = flush_vec[3];
    assign bus.o_flush_id_ex  = flush_vec[2];
    assign bus.o_flush_ex_mem = flush_vec[1];
    assign bus.o_flush_mem_wb = flush_vec[0];
    assign bus.o_halted       = halted_reg;
    assign bus.o_state        = state_reg;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_SIZE-1:0] cycle_cnt_reg, stall_cnt_reg;
    logic                active, enter_clear;

    assign active      = (state_reg == RUN) || (state_reg == STEP);
    assign enter_clear = (state_next == CLEAR) && (state_reg != CLEAR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cycle_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else if (enter_clear) begin
            cycle_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (active)
                cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (active && bus.i_load_use && !bus.i_halt_wb)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign bus.o_cycle_cnt = cycle_cnt_reg;
    assign bus.o_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; define PIPE_PERF_CNT_EN to also exercise the counters.
module tb_pipeline_ctrl;
    logic i_clk;
    logic i_reset;
    int   n_tests;
    int   n_fail;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.CLEAR_CYCLES(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [4:0] en_v();
        return {bus.o_en_pc, bus.o_en_if_id, bus.o_en_id_ex, bus.o_en_ex_mem, bus.o_en_mem_wb};
    endfunction

    function automatic logic [3:0] fl_v();
        return {bus.o_flush_if_id, bus.o_flush_id_ex, bus.o_flush_ex_mem, bus.o_flush_mem_wb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; new inputs are applied 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_reset = 1'b0;
        bus.i_start = 0; bus.i_step = 0; bus.i_restart = 0;
        bus.i_load_use = 0; bus.i_branch_taken = 0; bus.i_halt_wb = 0;

        // 1. reset
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b1;
        settle();
        chk("reset_state", 32'(bus.o_state), 32'd0);
        chk("reset_halted", 32'(bus.o_halted), 32'd0);
        chk("reset_en", 32'(en_v()), 32'h00);
        chk("reset_flush", 32'(fl_v()), 32'h0);

        // 2. start then load-use stall
        bus.i_start = 1;
        settle();
        chk("idle_en", 32'(en_v()), 32'h00);
        tick();
        bus.i_start = 0; bus.i_load_use = 1;
        settle();
        chk("run_state", 32'(bus.o_state), 32'd1);
        chk("lu_en", 32'(en_v()), 32'h07);
        chk("lu_flush", 32'(fl_v()), 32'h4);
        tick();
        bus.i_load_use = 0;
        settle();
        chk("run_en", 32'(en_v()), 32'h1f);
        chk("run_flush", 32'(fl_v()), 32'h0);

        // 3. load-use beats branch, then branch alone
        bus.i_load_use = 1; bus.i_branch_taken = 1;
        settle();
        chk("lu_br_flush", 32'(fl_v()), 32'h4);
        chk("lu_br_en", 32'(en_v()), 32'h07);
        tick();
        bus.i_load_use = 0;
        settle();
        chk("br_flush", 32'(fl_v()), 32'h8);
        chk("br_en", 32'(en_v()), 32'h1f);
        tick();
        bus.i_branch_taken = 0;

        // 5. halt, ignored start, restart through CLEAR
        bus.i_halt_wb = 1; bus.i_load_use = 1; bus.i_branch_taken = 1;
        settle();
        chk("halt_en", 32'(en_v()), 32'h00);
        chk("halt_flush", 32'(fl_v()), 32'h0);
        chk("halt_halted_pre", 32'(bus.o_halted), 32'd0);
        tick();
        bus.i_load_use = 0; bus.i_branch_taken = 0;
        settle();
        chk("halted_state", 32'(bus.o_state), 32'd3);
        chk("halted_flag", 32'(bus.o_halted), 32'd1);
        chk("halted_en", 32'(en_v()), 32'h00);
        bus.i_start = 1;
        tick();
        bus.i_start = 0;
        settle();
        chk("start_ignored", 32'(bus.o_state), 32'd3);
        bus.i_restart = 1;
        tick();
        bus.i_restart = 0; bus.i_halt_wb = 0;
        settle();
        chk("clear1_state", 32'(bus.o_state), 32'd4);
        chk("clear1_flush", 32'(fl_v()), 32'hf);
        chk("clear1_en", 32'(en_v()), 32'h00);
        chk("clear1_halted", 32'(bus.o_halted), 32'd0);
        tick();
        chk("clear2_state", 32'(bus.o_state), 32'd4);
        chk("clear2_flush", 32'(fl_v()), 32'hf);
        tick();
        chk("clear_done_state", 32'(bus.o_state), 32'd0);
        chk("clear_done_flush", 32'(fl_v()), 32'h0);

        // 4. held step gives one STEP cycle only
        bus.i_step = 1;
        tick();
        chk("step_state", 32'(bus.o_state), 32'd2);
        chk("step_en", 32'(en_v()), 32'h1f);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("step_hold_%0d", i), 32'(bus.o_state), 32'd0);
        end
        bus.i_step = 0;
        tick();
        bus.i_step = 1;
        tick();
        chk("step2_state", 32'(bus.o_state), 32'd2);
        bus.i_step = 0;
        tick();
        chk("step2_back_idle", 32'(bus.o_state), 32'd0);

        // step with halt goes to HALTED; async reset returns to IDLE at once
        bus.i_step = 1;
        tick();
        bus.i_step = 0; bus.i_halt_wb = 1;
        settle();
        chk("step_halt_en", 32'(en_v()), 32'h00);
        tick();
        bus.i_halt_wb = 0;
        chk("step_halt_state", 32'(bus.o_state), 32'd3);
        i_reset = 1'b0;
        settle();
        chk("async_rst_state", 32'(bus.o_state), 32'd0);
        chk("async_rst_halted", 32'(bus.o_halted), 32'd0);
        tick();
        i_reset = 1'b1;

        // simultaneous start and step: start wins
        bus.i_start = 1; bus.i_step = 1;
        tick();
        bus.i_start = 0; bus.i_step = 0;
        chk("start_beats_step", 32'(bus.o_state), 32'd1);
        tick();
        chk("run_persists", 32'(bus.o_state), 32'd1);

`ifdef PIPE_PERF_CNT_EN
        // 6. performance counters
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        chk("cnt_reset_cycle", 32'(bus.o_cycle_cnt), 32'd0);
        bus.i_start = 1;
        tick();
        bus.i_start = 0;
        for (int i = 0; i < 10; i++) begin
            bus.i_load_use = (i == 2 || i == 5 || i == 8);
            tick();
        end
        bus.i_load_use = 0;
        chk("cycle_cnt10", 32'(bus.o_cycle_cnt), 32'd10);
        chk("stall_cnt3", 32'(bus.o_stall_cnt), 32'd3);
        bus.i_halt_wb = 1; bus.i_load_use = 1;
        tick();
        bus.i_load_use = 0;
        chk("cycle_cnt_halt", 32'(bus.o_cycle_cnt), 32'd11);
        chk("stall_cnt_halt", 32'(bus.o_stall_cnt), 32'd3);
        bus.i_restart = 1;
        tick();
        bus.i_restart = 0; bus.i_halt_wb = 0;
        chk("cycle_cnt_clear", 32'(bus.o_cycle_cnt), 32'd0);
        chk("stall_cnt_clear", 32'(bus.o_stall_cnt), 32'd0);
        tick();
        tick();
        bus.i_start = 1;
        tick();
        bus.i_start = 0; bus.i_load_use = 1;
        tick();
        bus.i_load_use = 0; bus.i_halt_wb = 1;
        tick();
        bus.i_restart = 1;
        tick();
        bus.i_restart = 0; bus.i_halt_wb = 0;
        chk("midclear_state", 32'(bus.o_state), 32'd4);
        i_reset = 1'b0;
        settle();
        chk("midclear_rst_state", 32'(bus.o_state), 32'd0);
        chk("midclear_rst_cycle", 32'(bus.o_cycle_cnt), 32'd0);
        chk("midclear_rst_stall", 32'(bus.o_stall_cnt), 32'd0);
        tick();
        i_reset = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
